// File: rtl/maxpool_snake.sv
// 2x2 stride-2 max-pool over a snake-ordered activation stream (even rows L->R, odd rows R->L).
// Latency: pooled result registered 1 cycle after the edge accepting the window's last pixel.
// Backpressure: none downstream; upstream stalls by dropping in_valid, and every out_valid must be taken.
//
// Optional build macro MAXPOOL_SIGNED_EN: when defined, all max comparisons are two's-complement
// signed (pre-ReLU layers); when undefined, comparisons are unsigned.
//
// Even rows push horizontal pair maxima onto a small register LIFO. The following odd row arrives
// reversed, so popping the LIFO yields the partner pair of the same columns without any reordering.

module maxpool_snake #(
    parameter int DATA_W   = 8,
    parameter int MAX_SIZE = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        SIZE_maxpooling_IN,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [6:0]        out_col,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = MAX_SIZE / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVEN = 2'd1,
        S_ODD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Max of two activations; signedness selected at build time.
    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) >= $signed(b)) ? a : b;
`else
        return (a >= b) ? a : b;
`endif
    endfunction

    state_t            r_state;
    logic [7:0]        r_size;
    logic [7:0]        r_col_cnt;
    logic [7:0]        r_row_cnt;
    logic [PTR_W-1:0]  r_ptr;
    logic [DATA_W-1:0] r_pair;
    logic [DATA_W-1:0] r_lifo [DEPTH];
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [6:0]        r_out_col;
    logic              r_done;
    logic              r_err;

    logic              w_active;
    logic              w_accept;
    logic              w_second;
    logic              w_row_end;
    logic              w_last_row;
    logic              w_size_ok;
    logic              w_push;
    logic [DATA_W-1:0] w_hmax;
    logic [AW-1:0]     w_push_addr;
    logic [AW-1:0]     w_pop_addr;
    logic [DATA_W-1:0] w_popped;

    assign w_active    = (r_state == S_EVEN) || (r_state == S_ODD);
    assign w_accept    = en && in_valid && w_active;
    // Column counter parity marks the second pixel of each scan-order pair.
    assign w_second    = r_col_cnt[0];
    assign w_row_end   = (r_col_cnt == (r_size - 8'd1));
    assign w_last_row  = (r_row_cnt == (r_size - 8'd1));
    assign w_size_ok   = (SIZE_maxpooling_IN != 8'd0) && !SIZE_maxpooling_IN[0];
    assign w_hmax      = f_max(r_pair, in_data);
    assign w_push      = w_accept && w_second && (r_state == S_EVEN);
    assign w_push_addr = r_ptr[AW-1:0];
    assign w_pop_addr  = AW'(r_ptr - PTR_W'(1));
    assign w_popped    = r_lifo[w_pop_addr];

    // LIFO storage: written only by even rows; odd rows read the entry just below the pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lifo[w_push_addr] <= w_hmax;
        end
    end

    // Control FSM, counters, pair latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_size      <= 8'd0;
            r_col_cnt   <= 8'd0;
            r_row_cnt   <= 8'd0;
            r_ptr       <= '0;
            r_pair      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_col   <= 7'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Output strobes are single-cycle pulses.
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            if (!en) begin
                // Layer disabled: return to a clean idle, wiping any partial frame.
                r_state    <= S_IDLE;
                r_col_cnt  <= 8'd0;
                r_row_cnt  <= 8'd0;
                r_ptr      <= '0;
                r_pair     <= '0;
                r_out_data <= '0;
                r_out_col  <= 7'd0;
                r_err      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // An illegal size parks the block with err set until en drops.
                        if (!r_err) begin
                            if (w_size_ok) begin
                                r_size    <= SIZE_maxpooling_IN;
                                r_col_cnt <= 8'd0;
                                r_row_cnt <= 8'd0;
                                r_ptr     <= '0;
                                r_state   <= S_EVEN;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_EVEN, S_ODD: begin
                        if (in_valid) begin
                            if (!w_second) begin
                                r_pair <= in_data;
                            end else if (r_state == S_EVEN) begin
                                r_ptr <= r_ptr + PTR_W'(1);
                            end else begin
                                r_ptr       <= r_ptr - PTR_W'(1);
                                r_out_valid <= 1'b1;
                                r_out_data  <= f_max(w_hmax, w_popped);
                                r_out_col   <= 7'(w_pop_addr);
                            end

                            if (w_row_end) begin
                                // Row turnaround costs no bubble: next pixel may arrive next edge.
                                r_col_cnt <= 8'd0;
                                r_row_cnt <= r_row_cnt + 8'd1;
                                if (r_state == S_EVEN) begin
                                    r_state <= S_ODD;
                                end else if (w_last_row) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= S_EVEN;
                                end
                            end else begin
                                r_col_cnt <= r_col_cnt + 8'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_col   = r_out_col;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_maxpool_snake.sv
// Scoreboard bench for maxpool_snake: images are held as 2-D arrays, expected windows are the max
// of four pixels, and a separate monitor checks every out_valid against the queued expectation.
// Each expectation also records the cycle its output must appear (one edge after acceptance).

module tb_maxpool_snake;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] size;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic [6:0] out_col;
    logic       done;
    logic       err;

    maxpool_snake #(.DATA_W(8), .MAX_SIZE(256)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .en                 (en),
        .SIZE_maxpooling_IN (size),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_col            (out_col),
        .done               (done),
        .err                (err)
    );

    typedef struct {
        int d;
        int col;
        int dn;
        int cyc;
    } exp_t;

    exp_t sb[$];
    logic [7:0] img [0:15][0:15];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_chk = n_chk + 1;
        if (act !== expv) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int tmax(input int a, input int b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(8'(a)) >= $signed(8'(b))) ? a : b;
`else
        return (a >= b) ? a : b;
`endif
    endfunction

    // Pooled value of the window whose top-left pixel is (r, c).
    function automatic int pool(input int r, input int c);
        return tmax(tmax(int'(img[r][c]), int'(img[r][c+1])),
                    tmax(int'(img[r+1][c]), int'(img[r+1][c+1])));
    endfunction

    // Monitor: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", int'(out_data), e.d);
                    chk("out_col", int'(out_col), e.col);
                    chk("done_with_out", int'(done), e.dn);
                    chk("latency", cyc, e.cyc);
                end
            end else if (done) begin
                chk("done_without_out", 1, 0);
            end
        end
    end

    task automatic fill_basic(input int s);
        for (int r = 0; r < s; r++)
            for (int c = 0; c < s; c++)
                img[r][c] = 8'(r * s + c);
    endtask

    task automatic fill_rand(input int s);
        for (int r = 0; r < s; r++)
            for (int c = 0; c < s; c++)
                img[r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic start(input int s);
        @(negedge clk);
        en   = 1'b0;
        size = 8'(s);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: continuous, 1: 3 idle cycles after every 2nd pixel, 2: random gaps.
    task automatic run_img(input int s, input int mode, input int npix);
        int n = 0;
        for (int r = 0; r < s; r++) begin
            for (int k = 0; k < s; k++) begin
                int c;
                c = (r % 2 == 0) ? k : s - 1 - k;
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = img[r][c];
                if ((r % 2 == 1) && (k % 2 == 1)) begin
                    exp_t e;
                    e.d   = pool(r - 1, c);
                    e.col = c / 2;
                    e.dn  = (r == s - 1 && k == s - 1) ? 1 : 0;
                    e.cyc = cyc + 1;
                    sb.push_back(e);
                end
                n++;
                if (n == npix) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    return;
                end
                if (mode == 1 && n % 2 == 0) idle(3);
                else if (mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk(name, sb.size(), 0);
    endtask

    // After a complete frame the block sits in DONE and ignores further pixels.
    task automatic check_done_hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hff;
            chk("done_hold_no_out", int'(out_valid), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_hold_no_out", int'(out_valid), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        size     = 8'd4;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_col", int'(out_col), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ramp image, continuous stream.
        fill_basic(4);
        start(4);
        run_img(4, 0, 1000);
        drain("basic_drain");
        check_done_hold();

        // Same image with stalls after every second pixel.
        start(4);
        run_img(4, 1, 1000);
        drain("stall_drain");

        // Signedness corner on a 2x2 frame.
        img[0][0] = 8'h80; img[0][1] = 8'h01;
        img[1][0] = 8'h01; img[1][1] = 8'h01;
        start(2);
        run_img(2, 0, 1000);
        drain("sign_drain");

        // Illegal sizes: err set, no outputs, cleared by en low.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            en   = 1'b0;
            size = (t == 0) ? 8'd5 : 8'd0;
            @(negedge clk);
            en = 1'b1;
            repeat (2) @(negedge clk);
            chk("illegal_err_set", int'(err), 1);
            for (int i = 0; i < 20; i++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom_range(0, 255));
                @(negedge clk);
                chk("illegal_no_out", int'(out_valid), 0);
            end
            in_valid = 1'b0;
            en = 1'b0;
            @(negedge clk);
            chk("illegal_err_clear", int'(err), 0);
        end

        // Abort mid odd row with large random data, then replay the ramp image.
        fill_rand(4);
        for (int c = 0; c < 4; c++) begin
            img[0][c] = 8'hf0 | 8'(c);
            img[1][c] = 8'he0 | 8'(c);
        end
        start(4);
        run_img(4, 0, 6);
        drain("abort_partial_drain");
        en = 1'b0;
        @(negedge clk);
        chk("abort_out_data_zero", int'(out_data), 0);
        chk("abort_out_col_zero", int'(out_col), 0);
        chk("abort_out_valid_zero", int'(out_valid), 0);
        fill_basic(4);
        start(4);
        run_img(4, 0, 1000);
        drain("abort_replay_drain");

        // Randomised frames with random gaps.
        for (int t = 0; t < 6; t++) begin
            int s;
            s = 2 * $urandom_range(1, 8);
            fill_rand(s);
            start(s);
            run_img(s, 2, 1000);
            drain("rand_drain");
        end

        // Asynchronous reset while an odd-row result is on the outputs.
        fill_basic(4);
        start(4);
        run_img(4, 0, 5);
        in_valid = 1'b1;
        in_data  = img[1][2];
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", int'(out_valid), 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        en       = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_data", int'(out_data), 0);
        chk("async_rst_out_col", int'(out_col), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/maxpool_snake.md
Name: maxpool_snake

Overview:
- 2x2 stride-2 max-pooling stage that sits directly downstream of the serpentine-scan reuse stack in the CCM.
- Consumes the 8-bit activation stream in snake order: even rows scan left→right, odd rows scan right→left.
- Horizontal pair maxima of each even row are kept in a LIFO register array. The reversed odd row pops them in matching column order, so no reorder buffer is needed.
- Emits one pooled value per 2x2 window, tagged with its pooled column index.

Parameters:
- DATA_W, 8, activation width.
- MAX_SIZE, 256, largest supported input feature-map side; LIFO depth is MAX_SIZE/2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- en  input  1  layer enable; low synchronously clears the block to IDLE
- SIZE_maxpooling_IN  input  8  input feature-map side (square); must be even, ≥2
- in_valid  input  1  in_data valid this cycle
- in_data  input  DATA_W  activation in snake order
- out_valid  output  1  pooled result valid (single-cycle pulse)
- out_data  output  DATA_W  pooled maximum
- out_col  output  7  pooled column index of out_data
- done  output  1  one-cycle pulse after the last pooled output
- err  output  1  sticky: odd or zero SIZE_maxpooling_IN seen at start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_col=0, done=0, err=0, state=IDLE, counters=0, LIFO pointer=0, pair register=0.
- en low: next edge forces IDLE, clears counters, pointer and err; outputs go to 0.
- States:
  - IDLE: on en=1 go to EVEN if SIZE is even and nonzero. Otherwise set err and stay in IDLE until en drops.
  - EVEN: processes rows 0,2,4,...
  - ODD: processes rows 1,3,5,...
  - DONE: holds until en drops.
- Counters: col_cnt (0..SIZE-1) and row_cnt (0..SIZE-1) advance only on in_valid; gaps in in_valid stall everything. in_valid in IDLE/DONE is ignored.
- Pairing: the first pixel of each scan-order pair (col_cnt even) is latched in pair_reg. On the second pixel, hmax = max(pair_reg, in_data).
- EVEN row: push hmax to the LIFO at ptr, then ptr+1. At col_cnt==SIZE-1, go to ODD; ptr then equals SIZE/2.
- ODD row, second pixel of a pair:
  - ptr-1, pop that entry.
  - Registered next cycle: out_data = max(hmax, popped), out_col = ptr-1, out_valid=1.
  - Latency: 1 cycle after the accepting edge.
  - At col_cnt==SIZE-1: if row_cnt==SIZE-1, go to DONE and pulse done in the same cycle as the final out_valid. Otherwise go to EVEN.
- Output order: pooled columns come out descending, SIZE/2-1 down to 0, for every pooled row.
- Compare semantics: unsigned by default; ties keep either operand (same value).
- LIFO is an 8-bit register array, not SRAM. ptr never under- or overflows for legal SIZE; no full/empty flags.
- No output backpressure; the consumer must accept every out_valid.
- Row transitions: EVEN→ODD and ODD→EVEN take zero bubble cycles; a pixel may arrive on the very next edge.

Optional Feature:
- Macro MAXPOOL_SIGNED_EN.
- Defined: all max comparisons treat data as two's-complement signed (pre-ReLU layers).
- Undefined: comparisons are unsigned.

Test Plan:
- Basic, SIZE=4, pixel value r*4+c fed snake (0,1,2,3,7,6,5,4,8,9,10,11,15,14,13,12), in_valid continuous → (out_data,out_col) = (7,1),(5,0),(15,1),(13,0); done coincides with the 4th out_valid; then DONE.
- Stall: same stream with in_valid low for 3 cycles after every 2nd pixel → identical outputs; each out_valid arrives exactly 1 cycle after its accepting edge.
- Sign: pixels 0x80,0x01,0x01,0x01 (SIZE=2, fed 0x80,0x01 then 0x01,0x01) → out_data 0x80 without the macro, 0x01 with MAXPOOL_SIGNED_EN.
- Illegal size: SIZE=5 with en=1 → err=1, no out_valid for 20 supplied pixels; en low → err clears.
- Abort: drop en mid-row 1 of SIZE=4, re-raise, replay the full stream → the basic-test results, with no stale LIFO data.
- Reset: assert rst_n low asynchronously mid-ODD row → all outputs 0 immediately, without waiting for a clock edge.
